// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared types and encodings for the core memory arbiter.
//   arb_state_t : arbiter FSM states (idle, fetch owns bus, data owns bus)
//   SIZE_B/H/W  : access size encodings carried on the *_mask buses
// ----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/core_mem_arbiter.sv
// ----------------------------------------------------------------------------
// core_mem_arbiter
// Shares one single-ported memory bus between the core's instruction-fetch
// and data interfaces. The data port wins arbitration by default; a
// starvation counter forces a fetch grant after STARVE_MAX consecutive data
// grants taken while a fetch was waiting. A timeout counter aborts a bus
// transaction that never acknowledges (TIMEOUT_CYC = 0 disables it).
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_instr_*  / o_instr_*    fetch request (level), read data, 1-cycle ack
//   i_data_*   / o_data_*     load/store request (level), read data, 1-cycle ack
//   o_mem_*                   latched bus request, held stable until done
//   i_mem_rd_data, i_mem_ack  bus read data and completion
//   o_grant_data              high while a data transaction owns the bus
//   o_err_timeout             1-cycle pulse when a transaction is aborted
//
// The requester acks and the timeout pulse are combinational on i_mem_ack /
// the timeout counter so the core sees completion in the same cycle as the
// bus. Everything else on the bus side is registered.
// ----------------------------------------------------------------------------
module core_mem_arbiter
    import core_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic            i_clk,
    input  logic            i_rst_n,

    input  logic [XLEN-1:0] i_instr_addr,
    input  logic            i_instr_req,
    output logic [XLEN-1:0] o_instr_data,
    output logic            o_instr_ack,

    input  logic [XLEN-1:0] i_data_addr,
    input  logic [XLEN-1:0] i_data_wr_data,
    input  logic [1:0]      i_data_mask,
    input  logic            i_data_wr_en,
    input  logic            i_data_req,
    output logic [XLEN-1:0] o_data_rd_data,
    output logic            o_data_ack,

    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wr_data,
    output logic [1:0]      o_mem_mask,
    output logic            o_mem_wr_en,
    output logic            o_mem_req,
    input  logic [XLEN-1:0] i_mem_rd_data,
    input  logic            i_mem_ack,

    output logic            o_grant_data,
    output logic            o_err_timeout
);

    // Counter widths leave headroom so the limits themselves are representable.
    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam int TW = $clog2(TIMEOUT_CYC + 2);

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic          TMO_EN     = (TIMEOUT_CYC > 0) ? 1'b1 : 1'b0;
    localparam logic [TW-1:0] TMO_LAST   = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : {TW{1'b0}};

    arb_state_t      state_r;
    arb_state_t      state_nxt_s;
    logic [SW-1:0]   starve_cnt_r;
    logic [SW-1:0]   starve_cnt_nxt_s;
    logic [TW-1:0]   tmo_cnt_r;
    logic [TW-1:0]   tmo_cnt_nxt_s;

    logic            grant_d_s;
    logic            grant_i_s;
    logic            instr_ack_s;
    logic            data_ack_s;
    logic            tmo_hit_s;
    logic            done_s;

    logic [XLEN-1:0] mem_addr_r;
    logic [XLEN-1:0] mem_wr_data_r;
    logic [1:0]      mem_mask_r;
    logic            mem_wr_en_r;
    logic            mem_req_r;
    logic            grant_data_r;

    // Next-state, arbitration and completion decode.
    always_comb begin
        state_nxt_s = state_r;
        grant_d_s   = 1'b0;
        grant_i_s   = 1'b0;
        instr_ack_s = 1'b0;
        data_ack_s  = 1'b0;
        tmo_hit_s   = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                // Data wins unless a waiting fetch has been passed over STARVE_MAX times.
                if (i_data_req && (!i_instr_req || (starve_cnt_r < STARVE_LIM))) begin
                    grant_d_s   = 1'b1;
                    state_nxt_s = ARB_BUSY_D;
                end else if (i_instr_req) begin
                    grant_i_s   = 1'b1;
                    state_nxt_s = ARB_BUSY_I;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                // An ack arriving in the timeout cycle still completes normally.
                if (i_mem_ack) begin
                    instr_ack_s = (state_r == ARB_BUSY_I);
                    data_ack_s  = (state_r == ARB_BUSY_D);
                    state_nxt_s = ARB_IDLE;
                end else if (TMO_EN && (tmo_cnt_r == TMO_LAST)) begin
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    assign done_s = instr_ack_s | data_ack_s | tmo_hit_s;

    // Starvation and timeout counter updates.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        tmo_cnt_nxt_s    = tmo_cnt_r;
        if (grant_i_s) begin
            starve_cnt_nxt_s = {SW{1'b0}};
        end else if (grant_d_s && i_instr_req && (starve_cnt_r < STARVE_LIM)) begin
            starve_cnt_nxt_s = starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
        if (grant_i_s || grant_d_s) begin
            tmo_cnt_nxt_s = {TW{1'b0}};
        end else if (TMO_EN && (state_r != ARB_IDLE) && !done_s) begin
            tmo_cnt_nxt_s = tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_nxt_s = tmo_cnt_r;
        end
    end

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ARB_IDLE;
            starve_cnt_r <= {SW{1'b0}};
            tmo_cnt_r    <= {TW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            tmo_cnt_r    <= tmo_cnt_nxt_s;
        end
    end

    // Bus-side request registers: loaded on grant, held while busy, request dropped on completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_addr_r    <= {XLEN{1'b0}};
            mem_wr_data_r <= {XLEN{1'b0}};
            mem_mask_r    <= SIZE_B;
            mem_wr_en_r   <= 1'b0;
            mem_req_r     <= 1'b0;
            grant_data_r  <= 1'b0;
        end else if (grant_d_s) begin
            mem_addr_r    <= i_data_addr;
            mem_wr_data_r <= i_data_wr_data;
            mem_mask_r    <= i_data_mask;
            mem_wr_en_r   <= i_data_wr_en;
            mem_req_r     <= 1'b1;
            grant_data_r  <= 1'b1;
        end else if (grant_i_s) begin
            // Fetches are always full-word reads with no store data.
            mem_addr_r    <= i_instr_addr;
            mem_wr_data_r <= {XLEN{1'b0}};
            mem_mask_r    <= SIZE_W;
            mem_wr_en_r   <= 1'b0;
            mem_req_r     <= 1'b1;
            grant_data_r  <= 1'b0;
        end else if (done_s) begin
            mem_req_r     <= 1'b0;
            grant_data_r  <= 1'b0;
        end else begin
            mem_req_r     <= mem_req_r;
            grant_data_r  <= grant_data_r;
        end
    end

    assign o_mem_addr     = mem_addr_r;
    assign o_mem_wr_data  = mem_wr_data_r;
    assign o_mem_mask     = mem_mask_r;
    assign o_mem_wr_en    = mem_wr_en_r;
    assign o_mem_req      = mem_req_r;
    assign o_grant_data   = grant_data_r;

    assign o_instr_ack    = instr_ack_s;
    assign o_data_ack     = data_ack_s;
    assign o_err_timeout  = tmo_hit_s;

    // Read data goes to both requesters; only the acked one consumes it.
    assign o_instr_data   = i_mem_rd_data;
    assign o_data_rd_data = i_mem_rd_data;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_core_mem_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared each cycle against a transaction-level reference model of the
// arbiter (who owns the bus, what was latched, how long it has waited).
// ----------------------------------------------------------------------------
module tb_core_mem_arbiter;
    import core_pkg::*;

    localparam int XLEN = 32;
    localparam int SMAX = 2;
    localparam int TMO  = 8;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [XLEN-1:0] i_instr_addr;
    logic            i_instr_req;
    logic [XLEN-1:0] o_instr_data;
    logic            o_instr_ack;
    logic [XLEN-1:0] i_data_addr;
    logic [XLEN-1:0] i_data_wr_data;
    logic [1:0]      i_data_mask;
    logic            i_data_wr_en;
    logic            i_data_req;
    logic [XLEN-1:0] o_data_rd_data;
    logic            o_data_ack;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wr_data;
    logic [1:0]      o_mem_mask;
    logic            o_mem_wr_en;
    logic            o_mem_req;
    logic [XLEN-1:0] i_mem_rd_data;
    logic            i_mem_ack;
    logic            o_grant_data;
    logic            o_err_timeout;

    always #5 i_clk = ~i_clk;

    core_mem_arbiter #(
        .XLEN        (XLEN),
        .STARVE_MAX  (SMAX),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_instr_addr   (i_instr_addr),
        .i_instr_req    (i_instr_req),
        .o_instr_data   (o_instr_data),
        .o_instr_ack    (o_instr_ack),
        .i_data_addr    (i_data_addr),
        .i_data_wr_data (i_data_wr_data),
        .i_data_mask    (i_data_mask),
        .i_data_wr_en   (i_data_wr_en),
        .i_data_req     (i_data_req),
        .o_data_rd_data (o_data_rd_data),
        .o_data_ack     (o_data_ack),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wr_data  (o_mem_wr_data),
        .o_mem_mask     (o_mem_mask),
        .o_mem_wr_en    (o_mem_wr_en),
        .o_mem_req      (o_mem_req),
        .i_mem_rd_data  (i_mem_rd_data),
        .i_mem_ack      (i_mem_ack),
        .o_grant_data   (o_grant_data),
        .o_err_timeout  (o_err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner 0 = nobody, 1 = fetch, 2 = data.
    int          m_owner;
    int          m_starve;
    int          m_wait;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_mask;
    logic        m_wen;

    // Observations taken from the DUT for scenario-level checks.
    int   n_iack = 0;
    int   n_dack = 0;
    int   n_err  = 0;
    logic prev_req = 1'b0;
    logic grant_log[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_starve = 0;
        m_wait   = 0;
        m_addr   = 32'h0;
        m_wdata  = 32'h0;
        m_mask   = 2'b00;
        m_wen    = 1'b0;
        prev_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req"},   32'(o_mem_req),     32'h0);
        check_eq({tag, "_gnt"},   32'(o_grant_data),  32'h0);
        check_eq({tag, "_addr"},  o_mem_addr,         32'h0);
        check_eq({tag, "_wdata"}, o_mem_wr_data,      32'h0);
        check_eq({tag, "_mask"},  32'(o_mem_mask),    32'h0);
        check_eq({tag, "_wen"},   32'(o_mem_wr_en),   32'h0);
        check_eq({tag, "_iack"},  32'(o_instr_ack),   32'h0);
        check_eq({tag, "_dack"},  32'(o_data_ack),    32'h0);
        check_eq({tag, "_err"},   32'(o_err_timeout), 32'h0);
    endtask

    // One clock cycle: drive at the falling edge, compare against the model, advance the model.
    task automatic step(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                        input logic [31:0] daddr, input logic [31:0] wdata,
                        input logic [1:0] dmask, input logic dwen, input logic mack);
        logic [31:0] rdata;
        logic        busy;
        logic        e_tmo;
        @(negedge i_clk);
        rdata          = $urandom;
        i_instr_req    = ireq;
        i_instr_addr   = iaddr;
        i_data_req     = dreq;
        i_data_addr    = daddr;
        i_data_wr_data = wdata;
        i_data_mask    = dmask;
        i_data_wr_en   = dwen;
        i_mem_ack      = mack;
        i_mem_rd_data  = rdata;
        #1;
        busy  = (m_owner != 0);
        e_tmo = busy && !mack && (m_wait == TMO - 1);
        check_eq("mem_req",   32'(o_mem_req),      32'(busy));
        check_eq("grant_d",   32'(o_grant_data),   32'(m_owner == 2));
        check_eq("mem_addr",  o_mem_addr,          m_addr);
        check_eq("mem_wdata", o_mem_wr_data,       m_wdata);
        check_eq("mem_mask",  32'(o_mem_mask),     32'(m_mask));
        check_eq("mem_wen",   32'(o_mem_wr_en),    32'(m_wen));
        check_eq("instr_ack", 32'(o_instr_ack),    32'((m_owner == 1) && mack));
        check_eq("data_ack",  32'(o_data_ack),     32'((m_owner == 2) && mack));
        check_eq("err_tmo",   32'(o_err_timeout),  32'(e_tmo));
        check_eq("instr_rd",  o_instr_data,        rdata);
        check_eq("data_rd",   o_data_rd_data,      rdata);

        if (o_instr_ack)   n_iack++;
        if (o_data_ack)    n_dack++;
        if (o_err_timeout) n_err++;
        if (o_mem_req && !prev_req) grant_log.push_back(o_grant_data);
        prev_req = o_mem_req;

        if (m_owner == 0) begin
            if (dreq && (!ireq || m_starve < SMAX)) begin
                m_owner = 2;
                m_addr  = daddr;
                m_wdata = wdata;
                m_mask  = dmask;
                m_wen   = dwen;
                m_wait  = 0;
                if (ireq && m_starve < SMAX) m_starve++;
            end else if (ireq) begin
                m_owner  = 1;
                m_addr   = iaddr;
                m_wdata  = 32'h0;
                m_mask   = SIZE_W;
                m_wen    = 1'b0;
                m_wait   = 0;
                m_starve = 0;
            end
        end else if (mack || e_tmo) begin
            m_owner = 0;
        end else begin
            m_wait++;
        end
    endtask

    task automatic idle_step(input logic mack);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, mack);
    endtask

    initial begin
        int          base;
        int          tmo_at;
        logic        exp_order[6];
        logic        r_ireq;
        logic        r_dreq;
        logic [31:0] r_ia;
        logic [31:0] r_da;
        logic [31:0] r_wd;
        logic [1:0]  r_mask;
        logic        r_wen;
        logic        r_ack;
        logic        hang;

        i_rst_n        = 1'b0;
        i_instr_req    = 1'b0;
        i_instr_addr   = 32'h0;
        i_data_req     = 1'b0;
        i_data_addr    = 32'h0;
        i_data_wr_data = 32'h0;
        i_data_mask    = 2'b00;
        i_data_wr_en   = 1'b0;
        i_mem_ack      = 1'b0;
        i_mem_rd_data  = 32'h0;
        model_reset();
        repeat (3) @(negedge i_clk);
        #1;
        check_all_zero("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Fetch only, ack two cycles after the bus request rises.
        base = n_iack;
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        check_eq("fetch_addr", o_mem_addr, 32'h100);
        check_eq("fetch_wen", 32'(o_mem_wr_en), 32'h0);
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
        check_eq("fetch_ack_now", 32'(o_instr_ack), 32'h1);
        idle_step(1'b0);
        check_eq("fetch_ack_cnt", 32'(n_iack - base), 32'h1);
        check_eq("fetch_idle", 32'(o_mem_req), 32'h0);

        // Both requesters held high with instant acks: D, D, I repeating.
        grant_log.delete();
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 32'h500, 1'b1, 32'h600, 32'h0, SIZE_W, 1'b0, 1'b1);
        end
        idle_step(1'b0);
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        check_eq("starve_ngrants", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < grant_log.size()) check_eq("starve_order", 32'(grant_log[k]), 32'(exp_order[k]));
        end

        // Store fields stay latched while the requester changes its inputs.
        step(1'b0, 32'h0, 1'b1, 32'h2000, 32'hDEADBEEF, SIZE_W, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 1'b1, $urandom, $urandom, SIZE_B, 1'b0, 1'b0);
            check_eq("store_addr",  o_mem_addr,          32'h2000);
            check_eq("store_wdata", o_mem_wr_data,       32'hDEADBEEF);
            check_eq("store_mask",  32'(o_mem_mask),     32'(SIZE_W));
            check_eq("store_wen",   32'(o_mem_wr_en),    32'h1);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, SIZE_B, 1'b0, 1'b1);
        check_eq("store_ack", 32'(o_data_ack), 32'h1);
        idle_step(1'b0);

        // Never acked: abort on the 8th busy cycle, requester never acked.
        base   = n_iack + n_dack;
        tmo_at = 0;
        step(1'b1, 32'h400, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            idle_step(1'b0);
            if (o_err_timeout && tmo_at == 0) tmo_at = k;
        end
        check_eq("tmo_cycle", 32'(tmo_at), 32'd8);
        check_eq("tmo_noack", 32'(n_iack + n_dack - base), 32'h0);

        // Ack on the 8th busy cycle wins over the timeout.
        base = n_err;
        step(1'b0, 32'h0, 1'b1, 32'h700, 32'h1234, SIZE_H, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            idle_step(k == 8);
        end
        check_eq("tmo_ack_wins", 32'(o_data_ack), 32'h1);
        check_eq("tmo_ack_noerr", 32'(n_err - base), 32'h0);

        // Bus ack with nobody waiting is ignored.
        base = n_iack + n_dack;
        repeat (3) idle_step(1'b1);
        check_eq("idle_ack_ign", 32'(n_iack + n_dack - base), 32'h0);
        check_eq("idle_ack_req", 32'(o_mem_req), 32'h0);

        // Asynchronous reset in the middle of a data transaction.
        step(1'b0, 32'h0, 1'b1, 32'h3000, 32'h55, SIZE_W, 1'b1, 1'b0);
        @(negedge i_clk);
        i_data_req = 1'b0;
        i_mem_ack  = 1'b0;
        #1;
        check_eq("rst_pre_busy", 32'(o_grant_data), 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        base = n_dack;
        repeat (2) idle_step(1'b1);
        check_eq("rst_late_ack", 32'(n_dack - base), 32'h0);

        // Randomized traffic with level requests and irregular bus latency.
        r_ireq = 1'b0;
        r_dreq = 1'b0;
        hang   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) r_ireq = ~r_ireq;
            if ($urandom_range(3) == 0) r_dreq = ~r_dreq;
            if ($urandom_range(40) == 0) hang = ~hang;
            r_ia   = $urandom;
            r_da   = $urandom;
            r_wd   = $urandom;
            r_mask = 2'($urandom_range(2));
            r_wen  = 1'($urandom_range(1));
            r_ack  = !hang && ($urandom_range(2) == 0);
            step(r_ireq, r_ia, r_dreq, r_da, r_wd, r_mask, r_wen, r_ack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
